bcd_counter_n: RTL and testbench

BCD_COUNTER_N -- requirements
Module: bcd_counter_n

---
 rtl/bcd_counter_n.sv | 63 ++++++
 tb/tb_bcd_counter_n.sv | 115 +++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: multi-decade up/down BCD counter with load, wrap/saturate boundaries and 7-segment decode
module bcd_counter_n #(
  parameter int DIGITS = 2,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tc
);
  logic [DIGITS:0]        cy, bw;
  logic [4*DIGITS-1:0]    inc, dec, lv;
  logic                   bnd;
  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: dec7 = 7'b1111110;
      4'd1: dec7 = 7'b0110000;
      4'd2: dec7 = 7'b1101101;
      4'd3: dec7 = 7'b1111001;
      4'd4: dec7 = 7'b0110011;
      4'd5: dec7 = 7'b1011011;
      4'd6: dec7 = 7'b1011111;
      4'd7: dec7 = 7'b1110000;
      4'd8: dec7 = 7'b1111111;
      default: dec7 = 7'b1111011;
    endcase
  endfunction
  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic [3:0] d, l;
    assign d = count[4*k+:4];
    assign l = load_val[4*k+:4];
    assign cy[k+1] = cy[k] & (d == 4'd9);
    assign bw[k+1] = bw[k] & (d == 4'd0);
    assign inc[4*k+:4] = cy[k] ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
    assign dec[4*k+:4] = bw[k] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
    assign lv[4*k+:4] = (l > 4'd9) ? 4'd9 : l;
    assign seg[7*k+:7] = dec7(d);
  end
  // cy/bw past the top digit are exactly the all-nines / all-zeros conditions
  assign bnd = up ? cy[DIGITS] : bw[DIGITS];
  // count and terminal-count register: reset > load > enabled step > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc <= 1'b0;
    end else if (load) begin
      count <= lv;
      tc <= 1'b0;
    end else if (en) begin
      count <= (SATURATE != 0 && bnd) ? count : (up ? inc : dec);
      tc <= bnd;
    end else begin
      tc <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: directed and random checks of bcd_counter_n against an integer reference model
module tb_bcd_counter_n;
  logic clk = 0, reset = 0, en = 0, up = 0, load = 0;
  logic [15:0] lvb = 0;
  logic [7:0] c0, c1;
  logic [15:0] c2;
  logic [13:0] s0, s1;
  logic [27:0] s2;
  logic t0, t1, t2;
  int errors = 0, checks = 0;
  int mv[3];
  bit mt[3];
  int dig[3] = '{2, 2, 4};
  bit sat[3] = '{0, 1, 0};
  logic [6:0] tbl[10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                          7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  bcd_counter_n #(.DIGITS(2), .SATURATE(0)) u0 (.clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lvb[7:0]), .count(c0), .seg(s0), .tc(t0));
  bcd_counter_n #(.DIGITS(2), .SATURATE(1)) u1 (.clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lvb[7:0]), .count(c1), .seg(s1), .tc(t1));
  bcd_counter_n #(.DIGITS(4), .SATURATE(0)) u2 (.clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lvb), .count(c2), .seg(s2), .tc(t2));
  always #5 clk = ~clk;
  function automatic int p10(input int k);
    p10 = 1;
    for (int i = 0; i < k; i++) p10 *= 10;
  endfunction
  function automatic logic [31:0] to_bcd(input int v, input int d);
    to_bcd = 0;
    for (int k = 0; k < d; k++) to_bcd[4*k+:4] = 4'((v / p10(k)) % 10);
  endfunction
  function automatic logic [55:0] to_seg(input int v, input int d);
    to_seg = 0;
    for (int k = 0; k < d; k++) to_seg[7*k+:7] = tbl[(v / p10(k)) % 10];
  endfunction
  function automatic int clampv(input logic [15:0] b, input int d);
    int n;
    clampv = 0;
    for (int k = 0; k < d; k++) begin
      n = int'(b[4*k+:4]);
      clampv += (n > 9 ? 9 : n) * p10(k);
    end
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all();
    chk("count0", 64'(c0), 64'(to_bcd(mv[0], 2)));
    chk("seg0", 64'(s0), 64'(to_seg(mv[0], 2)));
    chk("tc0", 64'(t0), 64'(mt[0]));
    chk("count1", 64'(c1), 64'(to_bcd(mv[1], 2)));
    chk("seg1", 64'(s1), 64'(to_seg(mv[1], 2)));
    chk("tc1", 64'(t1), 64'(mt[1]));
    chk("count2", 64'(c2), 64'(to_bcd(mv[2], 4)));
    chk("seg2", 64'(s2), 64'(to_seg(mv[2], 4)));
    chk("tc2", 64'(t2), 64'(mt[2]));
  endtask
  task automatic step(input bit r, input bit l, input bit e, input bit u, input logic [15:0] v);
    int mx;
    bit b;
    reset = r; load = l; en = e; up = u; lvb = v;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      mx = p10(dig[i]) - 1;
      if (r) begin
        mv[i] = 0; mt[i] = 0;
      end else if (l) begin
        mv[i] = clampv(v, dig[i]); mt[i] = 0;
      end else if (e) begin
        b = u ? (mv[i] == mx) : (mv[i] == 0);
        mt[i] = b;
        if (!(b && sat[i])) mv[i] = u ? (b ? 0 : mv[i] + 1) : (b ? mx : mv[i] - 1);
      end else mt[i] = 0;
    end
    #1 chk_all();
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    chk("reset_seg", 64'(s0), 64'(14'b1111110_1111110));
    for (int i = 0; i < 100; i++) step(0, 0, 1, 1, 0);
    chk("wrap_up_tc", 64'(t0), 64'd1);
    step(0, 1, 0, 0, 16'h0005);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    chk("wrap_dn_val", 64'(c0), 64'h98);
    step(0, 1, 0, 0, 16'h0098);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    chk("sat_hold", 64'(c1), 64'h99);
    step(0, 0, 1, 0, 0);
    chk("sat_down", 64'(c1), 64'h98);
    step(0, 1, 1, 1, 16'h00A7);
    chk("load_clamp", 64'(c0), 64'h97);
    step(0, 1, 0, 0, 16'h0040);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("at_42", 64'(c0), 64'h42);
    step(1, 1, 1, 1, 16'h0077);
    chk("reset_override", 64'(c0), 64'h00);
    step(0, 1, 0, 0, 16'h0999);
    step(0, 0, 1, 1, 0);
    chk("d4_carry", 64'(c2), 64'h1000);
    step(0, 1, 0, 0, 16'h9999);
    step(0, 0, 1, 1, 0);
    chk("d4_wrap_tc", 64'(t2), 64'd1);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
           1'($urandom), 16'($urandom));
    for (int i = 0; i < 60; i++) step(0, i == 0, 1, i % 3 != 1, 16'h9990);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
